bus_master_ctrl: RTL



---
 rtl/bus_master_ctrl_pkg.sv | 23 ++
 rtl/bus_master_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/bus_master_ctrl_pkg.sv
// Shared bus definitions: interface FSM encoding, bus widths,
// read/write codes, active-low levels and the default slave timeout.
package bus_master_ctrl_pkg;

    typedef enum logic [1:0] {
        BUS_IF_STATE_IDLE   = 2'd0,
        BUS_IF_STATE_REQ    = 2'd1,
        BUS_IF_STATE_ACCESS = 2'd2,
        BUS_IF_STATE_WAIT   = 2'd3
    } bus_if_state_e;

    localparam int   BUS_ADDR_W      = 30;
    localparam int   BUS_DATA_W      = 32;
    localparam int   BUS_TIMEOUT_DEF = 255;
    localparam int   BUS_CNT_W       = 8;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_master_ctrl.sv
// Master-side bus controller: arbiter request/grant, then slave
// strobe/ready handshake, returning read data or a timeout error.
import bus_master_ctrl_pkg::*;

module bus_master_ctrl #(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = BUS_TIMEOUT_DEF,
    parameter int CNT_W   = BUS_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_req,
    input  logic              acc_rw,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wr_data,
    output logic              acc_busy,
    output logic              acc_done,
    output logic              acc_err,
    output logic [DATA_W-1:0] acc_rd_data,
    output logic              bus_req_n,
    input  logic              bus_grnt_n,
    output logic              bus_as_n,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_n
);

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);

    bus_if_state_e     r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_req_n;
    logic              r_as_n;
    logic              r_bus_rw;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wr_data;

    logic w_on_bus;
    logic w_rdy;
    logic w_tmo;
    logic w_fin;

    // Ready beats timeout when both land in the same WAIT cycle.
    always_comb begin
        w_on_bus = (r_state == BUS_IF_STATE_ACCESS) ||
                   (r_state == BUS_IF_STATE_WAIT);
        w_rdy    = w_on_bus && (bus_rdy_n == ENABLE_);
        w_tmo    = (r_state == BUS_IF_STATE_WAIT) &&
                   (bus_rdy_n == DISABLE_) &&
                   (r_cnt == LP_TIMEOUT);
        w_fin    = w_rdy || w_tmo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= BUS_IF_STATE_IDLE;
            r_cnt         <= '0;
            r_rw          <= BUS_READ;
            r_addr        <= '0;
            r_wr_data     <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_rd_data     <= '0;
            r_req_n       <= DISABLE_;
            r_as_n        <= DISABLE_;
            r_bus_rw      <= BUS_READ;
            r_bus_addr    <= '0;
            r_bus_wr_data <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                BUS_IF_STATE_IDLE: begin
                    if (acc_req) begin
                        r_rw      <= acc_rw;
                        r_addr    <= acc_addr;
                        r_wr_data <= acc_wr_data;
                        r_req_n   <= ENABLE_;
                        r_state   <= BUS_IF_STATE_REQ;
                    end
                end
                BUS_IF_STATE_REQ: begin
                    if (bus_grnt_n == ENABLE_) begin
                        r_as_n        <= ENABLE_;
                        r_bus_rw      <= r_rw;
                        r_bus_addr    <= r_addr;
                        r_bus_wr_data <= r_wr_data;
                        r_state       <= BUS_IF_STATE_ACCESS;
                    end
                end
                BUS_IF_STATE_ACCESS: begin
                    r_as_n  <= DISABLE_;
                    r_cnt   <= CNT_W'(1);
                    r_state <= BUS_IF_STATE_WAIT;
                end
                BUS_IF_STATE_WAIT: begin
                    if (!w_fin) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
            // Completion overrides the per-state updates above.
            if (w_fin) begin
                r_done <= 1'b1;
                r_err  <= w_tmo;
                if (w_rdy && (r_rw == BUS_READ)) begin
                    r_rd_data <= bus_rd_data;
                end
                r_req_n       <= DISABLE_;
                r_as_n        <= DISABLE_;
                r_bus_rw      <= BUS_READ;
                r_bus_addr    <= '0;
                r_bus_wr_data <= '0;
                r_state       <= BUS_IF_STATE_IDLE;
            end
        end
    end

    assign acc_busy    = (r_state != BUS_IF_STATE_IDLE);
    assign acc_done    = r_done;
    assign acc_err     = r_err;
    assign acc_rd_data = r_rd_data;
    assign bus_req_n   = r_req_n;
    assign bus_as_n    = r_as_n;
    assign bus_rw      = r_bus_rw;
    assign bus_addr    = r_bus_addr;
    assign bus_wr_data = r_bus_wr_data;

endmodule
